lfsr_test_ctrl: RTL and testbench

Sequencer for the PRBS self-test path: it drives the Galois LFSR generator and the LFSR lock checker through a complete test run. A run loads a seed into the generator, waits for the checker to lock, holds `o_valid` for a programmed number of cycles, counts cycles without lock, and reports pass/fail. It sits between the host/control registers and the generator/checker pair, and owns their `i_valid`, `i_soft_reset` and `i_seed` inputs.

---
 rtl/lfsr_test_ctrl.sv | 137 +++++++++++++
 tb/tb_lfsr_test_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_test_ctrl.sv
// Test-run sequencer for the PRBS generator/checker pair: seed load, lock acquisition,
// timed run with error counting, and a registered pass/fail result.
module lfsr_test_ctrl #(
   parameter int unsigned NB_SEED      = 8,
   parameter int unsigned NB_CNT       = 16,
   parameter int unsigned LOCK_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [NB_SEED-1:0] i_seed,
   input  logic [NB_CNT-1:0]  i_test_len,
   input  logic               i_lock,
   output logic               o_valid,
   output logic               o_soft_reset,
   output logic [NB_SEED-1:0] o_seed,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic               o_timeout,
   output logic               o_aborted,
   output logic [NB_CNT-1:0]  o_err_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StAcquire,
      StRun,
      StDone
   } state_e;

   state_e            state_q;
   logic [NB_CNT-1:0] len_q;
   logic [NB_CNT-1:0] to_cnt_q;
   logic [NB_CNT-1:0] run_cnt_q;
   logic [NB_CNT-1:0] err_next;
   logic              to_last;
   logic              run_last;

   // Error count including the current RUN cycle, saturating at all-ones.
   assign err_next = (i_lock || (o_err_cnt == {NB_CNT{1'b1}})) ? o_err_cnt
                                                               : o_err_cnt + NB_CNT'(1);
   assign to_last  = (to_cnt_q == NB_CNT'(LOCK_TIMEOUT - 1));
   assign run_last = (run_cnt_q == len_q - NB_CNT'(1));

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q      <= StIdle;
         len_q        <= '0;
         to_cnt_q     <= '0;
         run_cnt_q    <= '0;
         o_valid      <= 1'b0;
         o_soft_reset <= 1'b0;
         o_seed       <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_pass       <= 1'b0;
         o_timeout    <= 1'b0;
         o_aborted    <= 1'b0;
         o_err_cnt    <= '0;
      end else begin
         o_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (i_start) begin
                  o_seed    <= i_seed;
                  len_q     <= i_test_len;
                  to_cnt_q  <= '0;
                  run_cnt_q <= '0;
                  o_pass    <= 1'b0;
                  o_timeout <= 1'b0;
                  o_aborted <= 1'b0;
                  o_err_cnt <= '0;
                  if (i_test_len != '0) begin
                     state_q      <= StLoad;
                     o_soft_reset <= 1'b1;
                     o_busy       <= 1'b1;
                  end else begin
                     state_q <= StDone;
                     o_done  <= 1'b1;
                  end
               end
            end
            StLoad: begin
               state_q      <= StAcquire;
               o_soft_reset <= 1'b0;
               o_valid      <= 1'b1;
            end
            StAcquire: begin
               to_cnt_q <= to_cnt_q + NB_CNT'(1);
               if (i_abort) begin
                  state_q   <= StDone;
                  o_done    <= 1'b1;
                  o_valid   <= 1'b0;
                  o_busy    <= 1'b0;
                  o_aborted <= 1'b1;
               end else if (i_lock) begin
                  state_q <= StRun;
               end else if (to_last) begin
                  state_q   <= StDone;
                  o_done    <= 1'b1;
                  o_valid   <= 1'b0;
                  o_busy    <= 1'b0;
                  o_timeout <= 1'b1;
               end
            end
            StRun: begin
               run_cnt_q <= run_cnt_q + NB_CNT'(1);
               o_err_cnt <= err_next;
               if (i_abort) begin
                  state_q   <= StDone;
                  o_done    <= 1'b1;
                  o_valid   <= 1'b0;
                  o_busy    <= 1'b0;
                  o_aborted <= 1'b1;
               end else if (run_last) begin
                  // Timeout/abort flags are necessarily clear on this path.
                  state_q <= StDone;
                  o_done  <= 1'b1;
                  o_valid <= 1'b0;
                  o_busy  <= 1'b0;
                  o_pass  <= (err_next == '0);
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_test_ctrl.sv
// Self-checking bench for lfsr_test_ctrl: directed scenarios plus randomized runs
// compared against a run-level reference model.
module tb_lfsr_test_ctrl;

   localparam int NB_SEED = 8;
   localparam int NB_CNT  = 16;
   localparam int TO      = 64;
   localparam int NEVER   = 1000;

   logic               clk = 1'b0;
   logic               i_rst;
   logic               i_start;
   logic               i_abort;
   logic [NB_SEED-1:0] i_seed;
   logic [NB_CNT-1:0]  i_test_len;
   logic               i_lock;
   logic               o_valid;
   logic               o_soft_reset;
   logic [NB_SEED-1:0] o_seed;
   logic               o_busy;
   logic               o_done;
   logic               o_pass;
   logic               o_timeout;
   logic               o_aborted;
   logic [NB_CNT-1:0]  o_err_cnt;

   int checks   = 0;
   int failures = 0;
   bit lk[256];

   always #5 clk = ~clk;

   lfsr_test_ctrl #(
      .NB_SEED     (NB_SEED),
      .NB_CNT      (NB_CNT),
      .LOCK_TIMEOUT(TO)
   ) u_dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_abort     (i_abort),
      .i_seed      (i_seed),
      .i_test_len  (i_test_len),
      .i_lock      (i_lock),
      .o_valid     (o_valid),
      .o_soft_reset(o_soft_reset),
      .o_seed      (o_seed),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_pass      (o_pass),
      .o_timeout   (o_timeout),
      .o_aborted   (o_aborted),
      .o_err_cnt   (o_err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " valid"}, o_valid, 0);
      check({tag, " soft_reset"}, o_soft_reset, 0);
      check({tag, " seed"}, o_seed, 0);
      check({tag, " busy"}, o_busy, 0);
      check({tag, " done"}, o_done, 0);
      check({tag, " pass"}, o_pass, 0);
      check({tag, " timeout"}, o_timeout, 0);
      check({tag, " aborted"}, o_aborted, 0);
      check({tag, " err_cnt"}, o_err_cnt, 0);
   endtask

   function automatic void fill_lock(input int err_pct);
      for (int r = 0; r < 256; r++) lk[r] = ($urandom_range(0, 99) >= err_pct);
   endfunction

   // One complete run. lk[r] is the lock level in RUN cycle r (1-based); ACQUIRE sees lock
   // from cycle lock_at on; ab_acq/ab_run name the cycle in which abort is pulsed (0 = none).
   task automatic run_test(input string name, input logic [7:0] seed, input int len,
                           input int lock_at, input int ab_acq, input int ab_run,
                           input bit ab_load, input bit noisy);
      int  n_acq, n_run, tdone, err;
      bit  tmo, abt, locked, pass, ld, acq, run;
      n_acq = 0; n_run = 0; err = 0; tmo = 0; abt = 0; locked = 0;
      if (len != 0) begin
         for (int a = 1; a <= TO; a++) begin
            n_acq = a;
            if (ab_acq == a) begin abt = 1; break; end
            if (a >= lock_at) begin locked = 1; break; end
            if (a == TO) tmo = 1;
         end
         if (locked) begin
            for (int r = 1; r <= len; r++) begin
               n_run = r;
               if (!lk[r] && err < 65535) err++;
               if (ab_run == r) begin abt = 1; break; end
            end
         end
      end
      tdone = (len == 0) ? 1 : 2 + n_acq + n_run;
      pass  = (len != 0) && !tmo && !abt && (err == 0);

      i_start    = 1'b1;
      i_seed     = seed;
      i_test_len = NB_CNT'(len);
      i_abort    = 1'b0;
      i_lock     = 1'($urandom);
      tick();
      i_start = 1'b0;
      for (int t = 1; t <= tdone; t++) begin
         if (t > 1) tick();
         ld  = (len != 0) && (t == 1);
         acq = (len != 0) && (t >= 2) && (t <= 1 + n_acq);
         run = (len != 0) && (t > 1 + n_acq) && (t < tdone);
         check($sformatf("%s valid t=%0d", name, t), o_valid, 32'(acq || run));
         check($sformatf("%s soft_reset t=%0d", name, t), o_soft_reset, 32'(ld));
         check($sformatf("%s busy t=%0d", name, t), o_busy, 32'(ld || acq || run));
         check($sformatf("%s done t=%0d", name, t), o_done, 32'(t == tdone));
         check($sformatf("%s seed t=%0d", name, t), o_seed, 32'(seed));
         if (t < tdone) begin
            check($sformatf("%s pass early t=%0d", name, t), o_pass, 0);
            i_lock  = acq ? (t - 1 >= lock_at) : run ? lk[t - 1 - n_acq] : 1'($urandom);
            i_abort = ld ? ab_load : acq ? (t - 1 == ab_acq) : (t - 1 - n_acq == ab_run);
            if (noisy) begin
               i_start    = 1'($urandom);
               i_seed     = NB_SEED'($urandom);
               i_test_len = NB_CNT'($urandom);
            end
         end else begin
            check({name, " pass"}, o_pass, 32'(pass));
            check({name, " timeout"}, o_timeout, 32'(tmo));
            check({name, " aborted"}, o_aborted, 32'(abt));
            check({name, " err_cnt"}, o_err_cnt, 32'(err));
         end
      end
      i_start = 1'b0;
      i_abort = 1'b0;
      tick();
      check({name, " idle done"}, o_done, 0);
      check({name, " idle busy"}, o_busy, 0);
      check({name, " idle valid"}, o_valid, 0);
      check({name, " held pass"}, o_pass, 32'(pass));
      check({name, " held err_cnt"}, o_err_cnt, 32'(err));
   endtask

   initial begin
      i_rst      = 1'b1;
      i_start    = 1'b0;
      i_abort    = 1'b0;
      i_seed     = '0;
      i_test_len = '0;
      i_lock     = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      i_rst = 1'b0;
      tick();
      check_all_zero("post-reset idle");

      fill_lock(0);
      run_test("nominal", 8'hA5, 100, 3, 0, 0, 1'b0, 1'b0);
      for (int r = 40; r < 45; r++) lk[r] = 1'b0;
      run_test("lockloss", 8'hA5, 100, 3, 0, 0, 1'b0, 1'b0);
      fill_lock(0);
      run_test("timeout", 8'h5A, 10, NEVER, 0, 0, 1'b0, 1'b0);
      run_test("abort", 8'h77, 100, 3, 0, 20, 1'b0, 1'b1);
      run_test("zerolen", 8'hC3, 0, 1, 0, 0, 1'b0, 1'b0);
      run_test("minimal", 8'h01, 1, 1, 0, 0, 1'b1, 1'b0);

      // Reset in the middle of RUN.
      i_start    = 1'b1;
      i_seed     = 8'h3C;
      i_test_len = 16'd50;
      i_lock     = 1'b1;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check("midrun valid before reset", o_valid, 1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_all_zero("midrun reset");
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("after reset done k=%0d", k), o_done, 0);
         check($sformatf("after reset busy k=%0d", k), o_busy, 0);
      end
      run_test("after reset", 8'hA5, 20, 2, 0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         int len, lock_at, ab_acq, ab_run;
         len     = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 40));
         lock_at = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, 70));
         ab_acq  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 70)) : 0;
         ab_run  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 45)) : 0;
         fill_lock(($urandom_range(0, 1) == 0) ? 0 : 10);
         run_test($sformatf("rand%0d", n), 8'($urandom), len, lock_at, ab_acq, ab_run,
                  1'($urandom), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
